// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC/CTR block-cipher mode wrapper between word streams and an external cipher core
module aes_mode_engine #(
    parameter int STREAM_W = 32,
    parameter int BLOCK_W  = 128,
    parameter int CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [CNT_W-1:0]      len_i,
    input  logic [BLOCK_W-1:0]    iv_i,
    input  logic                  iv_load_i,
    input  logic [STREAM_W-1:0]   in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [STREAM_W-1:0]   key_data_i,
    input  logic                  key_valid_i,
    output logic                  key_ready_o,
    output logic [STREAM_W-1:0]   out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [STREAM_W/8-1:0] out_strb_o,
    output logic                  cph_ld_o,
    output logic [BLOCK_W-1:0]    cph_key_o,
    output logic [BLOCK_W-1:0]    cph_text_o,
    input  logic                  cph_done_i,
    input  logic [BLOCK_W-1:0]    cph_text_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      blk_cnt_o
);
    localparam int NW   = BLOCK_W / STREAM_W;
    localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_COLLECT, S_LOAD, S_CIPHER, S_DRAIN} state_t;

    state_t               r_state, w_next;
    logic [1:0]           r_mode;
    logic [CNT_W-1:0]     r_len, r_blk_cnt;
    logic [BLOCK_W-1:0]   r_iv, r_key, r_pt, r_chain, r_ctr, r_res;
    logic [WC_W-1:0]      r_wcnt;
    logic                 r_done;
    logic                 w_rst, w_start, w_key_hs, w_in_hs, w_out_hs, w_cph_hit;
    logic                 w_last_word, w_last_blk, w_cbc, w_ctr;

    assign w_rst       = rst_i | clear_i;
    assign w_start     = start_i && r_state == S_IDLE;
    assign w_key_hs    = key_valid_i & key_ready_o;
    assign w_in_hs     = in_valid_i & in_ready_o;
    assign w_out_hs    = out_valid_o & out_ready_i;
    assign w_cph_hit   = cph_done_i && r_state == S_CIPHER;
    assign w_last_word = r_wcnt == WC_W'(NW - 1);
    assign w_last_blk  = (r_blk_cnt + CNT_W'(1)) == r_len;
    assign w_cbc       = r_mode == 2'd1;
    assign w_ctr       = r_mode == 2'd2;

    assign out_data_o  = r_res[BLOCK_W-1 -: STREAM_W];
    assign out_strb_o  = '1;
    assign cph_key_o   = r_key;
    assign cph_text_o  = w_ctr ? r_ctr : w_cbc ? (r_pt ^ r_chain) : r_pt;
    assign busy_o      = r_state != S_IDLE;
    assign done_o      = r_done;
    assign blk_cnt_o   = r_blk_cnt;

    // State register; clear aborts any job back to idle
    always_ff @(posedge clk_i) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and per-state handshake enables
    always_comb begin
        w_next      = r_state;
        key_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        cph_ld_o    = 1'b0;
        case (r_state)
            S_IDLE:    if (start_i) w_next = (len_i == '0) ? S_IDLE : S_KEY;
            S_KEY: begin
                key_ready_o = 1'b1;
                if (key_valid_i && w_last_word) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                in_ready_o = 1'b1;
                if (in_valid_i && w_last_word) w_next = S_LOAD;
            end
            S_LOAD: begin
                cph_ld_o = 1'b1;
                w_next   = S_CIPHER;
            end
            S_CIPHER:  if (cph_done_i) w_next = S_DRAIN;
            S_DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i && w_last_word) w_next = w_last_blk ? S_IDLE : S_COLLECT;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // IV survives soft clear and persists across jobs
    always_ff @(posedge clk_i) begin
        if (rst_i)                               r_iv <= '0;
        else if (iv_load_i && r_state == S_IDLE) r_iv <= iv_i;
    end

    // Datapath: word packing, mode chaining, result unpacking and block counting
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_mode    <= '0;
            r_len     <= '0;
            r_blk_cnt <= '0;
            r_key     <= '0;
            r_pt      <= '0;
            r_chain   <= '0;
            r_ctr     <= '0;
            r_res     <= '0;
            r_wcnt    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_mode    <= mode_i;
                r_len     <= len_i;
                r_blk_cnt <= '0;
                r_chain   <= r_iv;
                r_ctr     <= r_iv;
                r_wcnt    <= '0;
                r_done    <= len_i == '0;
            end
            if (w_key_hs) r_key <= (r_key << STREAM_W) | BLOCK_W'(key_data_i);
            if (w_in_hs)  r_pt  <= (r_pt << STREAM_W) | BLOCK_W'(in_data_i);
            if (w_key_hs || w_in_hs || w_out_hs) r_wcnt <= w_last_word ? '0 : r_wcnt + WC_W'(1);
            if (w_cph_hit) begin
                r_res  <= w_ctr ? (cph_text_i ^ r_pt) : cph_text_i;
                r_wcnt <= '0;
                if (w_cbc) r_chain <= cph_text_i;
                if (w_ctr) r_ctr <= r_ctr + BLOCK_W'(1);
            end
            if (w_out_hs) begin
                r_res <= r_res << STREAM_W;
                if (w_last_word) begin
                    r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                    r_done    <= w_last_blk;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: directed-vector bench with a block-level mode model and a stand-in cipher core
module tb_aes_mode_engine;
    localparam int SW = 32;
    localparam int BW = 128;
    localparam int CW = 16;
    localparam int NW = BW / SW;

    localparam logic [BW-1:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BW-1:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BW-1:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [BW-1:0] IV_CBC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BW-1:0] IV_CTR  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [BW-1:0] PT_SP1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [BW-1:0] PT_SP2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i, clear_i, start_i, iv_load_i;
    logic [1:0]     mode_i;
    logic [CW-1:0]  len_i, blk_cnt_o;
    logic [BW-1:0]  iv_i, cph_key_o, cph_text_o, cph_text_i;
    logic [SW-1:0]  in_data_i, key_data_i, out_data_o;
    logic           in_valid_i, in_ready_o, key_valid_i, key_ready_o;
    logic           out_valid_o, out_ready_i, cph_ld_o, cph_done_i, busy_o, done_o;
    logic [SW/8-1:0] out_strb_o;

    aes_mode_engine #(.STREAM_W(SW), .BLOCK_W(BW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
        .len_i(len_i), .iv_i(iv_i), .iv_load_i(iv_load_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .key_data_i(key_data_i), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_strb_o(out_strb_o), .cph_ld_o(cph_ld_o), .cph_key_o(cph_key_o),
        .cph_text_o(cph_text_o), .cph_done_i(cph_done_i), .cph_text_i(cph_text_i),
        .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [SW-1:0] exp_q[$], recv_q[$], ref_q[$];
    logic [BW-1:0] exp_cin_q[$], exp_key_q[$];
    logic [BW-1:0] pt_mem [8];
    logic [BW-1:0] iv_model = '0;
    logic [BW-1:0] last_cin = '0;
    bit            stall_out = 1'b0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in cipher: real AES answers for the published vectors, a keyed scramble otherwise
    function automatic logic [BW-1:0] cipher(input logic [BW-1:0] k, input logic [BW-1:0] t);
        if (k == K_FIPS && t == PT_FIPS)                            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if (k == K_SP && t == 128'h6bc0bce12a459991e134741a7f9e1925) return 128'h7649abac8119b246cee98e9b12e9197d;
        if (k == K_SP && t == 128'hd86421fb9f1a1eda505ee1375746972c) return 128'h5086cb9b507219ee95db113a917678b2;
        if (k == K_SP && t == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff) return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
        if (k == K_SP && t == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00) return 128'h362b7c3c6773516318a077d7fc5073ae;
        return {t[63:0], t[127:64]} ^ (k * 128'h9e3779b97f4a7c15) ^ {t[126:0], t[127]};
    endfunction

    function automatic logic [BW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cipher core stub: latches operands at load, answers after 3..6 cycles even if the job was aborted
    int pend = 0;
    logic [BW-1:0] st_k, st_t;
    initial begin
        cph_done_i = 1'b0;
        cph_text_i = '0;
        forever begin
            @(posedge clk); #1;
            cph_done_i = 1'b0;
            if (cph_ld_o) begin
                st_k = cph_key_o;
                st_t = cph_text_o;
                pend = $urandom_range(3, 6);
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    cph_done_i = 1'b1;
                    cph_text_i = cipher(st_k, st_t);
                end
            end
        end
    end

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready_i = stall_out ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Compare process: output words, stall stability and cipher operands against the model queues
    initial begin
        bit            prev_stall = 1'b0;
        logic [SW-1:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("out_hold_valid", BW'(out_valid_o), 1);
                chk("out_hold_data", BW'(out_data_o), BW'(prev_data));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) chk("out_unexpected", BW'(out_valid_o), 0);
                else                   chk("out_word", BW'(out_data_o), BW'(exp_q.pop_front()));
                recv_q.push_back(out_data_o);
            end
            if (cph_ld_o) begin
                last_cin = cph_text_o;
                if (exp_cin_q.size() == 0) chk("ld_unexpected", BW'(cph_ld_o), 0);
                else begin
                    chk("cph_text", cph_text_o, exp_cin_q.pop_front());
                    chk("cph_key", cph_key_o, exp_key_q.pop_front());
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
        end
    end

    task automatic send_word(input bit is_key, input logic [SW-1:0] d, input bit stall);
        int t = 0;
        bit hs = 1'b0;
        bit v;
        while (!hs && t < 500) begin
            v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (is_key) begin
                key_valid_i = v;
                key_data_i  = v ? d : $urandom;
            end else begin
                in_valid_i = v;
                in_data_i  = v ? d : $urandom;
            end
            @(negedge clk);
            hs = v && (is_key ? key_ready_o : in_ready_o);
            @(posedge clk); #1;
            t++;
        end
        key_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        if (!hs) chk("feed_timeout", BW'(hs), 1);
    endtask

    // Model the whole job block by block, then drive it and wait for completion
    task automatic run_job(input logic [1:0] mode, input int len, input logic [BW-1:0] key,
                           input bit ld_iv, input logic [BW-1:0] iv, input bit stall);
        logic [BW-1:0] chain, ctr, cin, r;
        int t;
        if (ld_iv) iv_model = iv;
        chain = iv_model;
        ctr   = iv_model;
        for (int b = 0; b < len; b++) begin
            case (mode)
                2'd1: begin cin = pt_mem[b] ^ chain; r = cipher(key, cin); chain = r; end
                2'd2: begin cin = ctr; r = cipher(key, cin) ^ pt_mem[b]; ctr = ctr + 1; end
                default: begin cin = pt_mem[b]; r = cipher(key, cin); end
            endcase
            exp_cin_q.push_back(cin);
            exp_key_q.push_back(key);
            for (int i = 0; i < NW; i++) exp_q.push_back(r[BW-1-SW*i -: SW]);
        end
        recv_q.delete();
        stall_out = stall;
        if (ld_iv) begin
            iv_i = iv;
            iv_load_i = 1'b1;
            @(posedge clk); #1;
            iv_load_i = 1'b0;
        end
        mode_i  = mode;
        len_i   = CW'(len);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (len > 0) begin
            for (int i = 0; i < NW; i++) send_word(1'b1, key[BW-1-SW*i -: SW], stall);
            for (int b = 0; b < len; b++)
                for (int i = 0; i < NW; i++) send_word(1'b0, pt_mem[b][BW-1-SW*i -: SW], stall);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done_o && t < 3000);
        chk("done_seen", BW'(done_o), 1);
        if (len == 0) chk("done_latency_len0", BW'(t), 1);
        chk("blk_cnt_end", BW'(blk_cnt_o), BW'(len));
        chk("busy_end", BW'(busy_o), 0);
        chk("exp_drained", BW'(exp_q.size()), 0);
        @(negedge clk);
        chk("done_one_cycle", BW'(done_o), 0);
        @(posedge clk); #1;
        stall_out = 1'b0;
    endtask

    task automatic chk_blk(input string name, input int b, input logic [BW-1:0] exp);
        logic [BW-1:0] g = '0;
        for (int i = 0; i < NW; i++)
            g = (g << SW) | BW'((b * NW + i < recv_q.size()) ? recv_q[b * NW + i] : '0);
        chk(name, g, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [BW-1:0] k;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; iv_load_i = 1'b0;
        mode_i = '0; len_i = '0; iv_i = '0;
        in_data_i = '0; in_valid_i = 1'b0; key_data_i = '0; key_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", BW'(busy_o), 0);
        chk("rst_out_valid", BW'(out_valid_o), 0);
        chk("rst_in_ready", BW'(in_ready_o), 0);
        chk("rst_key_ready", BW'(key_ready_o), 0);
        chk("rst_cph_ld", BW'(cph_ld_o), 0);
        chk("rst_done", BW'(done_o), 0);
        chk("rst_blk_cnt", BW'(blk_cnt_o), 0);
        chk("rst_cph_key", cph_key_o, 0);
        chk("rst_cph_text", cph_text_o, 0);
        chk("rst_out_data", BW'(out_data_o), 0);
        chk("rst_strb", BW'(out_strb_o), BW'(4'hf));
        @(posedge clk); #1;

        pt_mem[0] = PT_FIPS;
        run_job(2'd0, 1, K_FIPS, 1'b0, '0, 1'b0);
        chk_blk("ecb_fips197", 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        run_job(2'd0, 0, K_FIPS, 1'b0, '0, 1'b0);

        pt_mem[0] = PT_SP1; pt_mem[1] = PT_SP2;
        run_job(2'd1, 2, K_SP, 1'b1, IV_CBC, 1'b0);
        chk_blk("cbc_f21_b1", 0, 128'h7649abac8119b246cee98e9b12e9197d);
        chk_blk("cbc_f21_b2", 1, 128'h5086cb9b507219ee95db113a917678b2);

        pt_mem[0] = rnd128(); pt_mem[1] = rnd128();
        run_job(2'd2, 2, rnd128(), 1'b1, '1, 1'b0);
        chk("ctr_wrap_to_zero", last_cin, 0);

        pt_mem[0] = PT_SP1; pt_mem[1] = PT_SP2;
        run_job(2'd2, 2, K_SP, 1'b1, IV_CTR, 1'b0);
        chk_blk("ctr_f51_b1", 0, 128'h874d6191b620e3261bef6864990db6ce);
        chk_blk("ctr_f51_b2", 1, 128'h9806f66b7970fdff8617187bb9fffdff);

        k = rnd128();
        for (int b = 0; b < 4; b++) pt_mem[b] = rnd128();
        run_job(2'd1, 4, k, 1'b1, IV_CBC, 1'b0);
        ref_q = recv_q;
        run_job(2'd1, 4, k, 1'b1, IV_CBC, 1'b1);
        chk("stall_word_count", BW'(recv_q.size()), BW'(ref_q.size()));
        for (int i = 0; i < 16; i++)
            chk("stall_same_data", BW'((i < recv_q.size()) ? recv_q[i] : '0), BW'((i < ref_q.size()) ? ref_q[i] : '1));

        pt_mem[0] = rnd128(); pt_mem[1] = rnd128();
        run_job(2'd3, 2, rnd128(), 1'b0, '0, 1'b0);

        pt_mem[0] = PT_FIPS;
        exp_cin_q.push_back(PT_FIPS);
        exp_key_q.push_back(K_FIPS);
        mode_i = 2'd0; len_i = CW'(1); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < NW; i++) send_word(1'b1, K_FIPS[BW-1-SW*i -: SW], 1'b0);
        for (int i = 0; i < NW; i++) send_word(1'b0, PT_FIPS[BW-1-SW*i -: SW], 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cph_ld_o && t < 50);
        chk("abort_ld_seen", BW'(cph_ld_o), 1);
        @(posedge clk); #1;
        clear_i = 1'b1; start_i = 1'b1; len_i = CW'(1);
        @(posedge clk); #1;
        clear_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", BW'(in_ready_o), 0);
        chk("abort_key_ready", BW'(key_ready_o), 0);
        repeat (10) begin
            chk("abort_busy", BW'(busy_o), 0);
            chk("abort_out_valid", BW'(out_valid_o), 0);
            chk("abort_blk_cnt", BW'(blk_cnt_o), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        pt_mem[0] = PT_SP1; pt_mem[1] = PT_SP2;
        run_job(2'd1, 2, K_SP, 1'b0, '0, 1'b0);
        chk_blk("cbc_after_clear_b1", 0, 128'h7649abac8119b246cee98e9b12e9197d);
        chk_blk("cbc_after_clear_b2", 1, 128'h5086cb9b507219ee95db113a917678b2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
